// File: rtl/turn_signal_ctrl_pkg.sv
// Shared definitions for the turn-indicator sequencer: state encoding and default timing.
// The dashboard display decodes turn_state from these same constants.
package turn_signal_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEFT   = 3'd1,
    ST_RIGHT  = 3'd2,
    ST_HAZARD = 3'd3,
    ST_LANE_L = 3'd4,
    ST_LANE_R = 3'd5
  } turn_state_e;

  localparam int unsigned DEF_HALF_PERIOD = 25_000_000;
  localparam int unsigned DEF_LANE_BLINKS = 3;

  function automatic logic lights_left(input turn_state_e s);
    return (s == ST_LEFT) || (s == ST_HAZARD) || (s == ST_LANE_L);
  endfunction

  function automatic logic lights_right(input turn_state_e s);
    return (s == ST_RIGHT) || (s == ST_HAZARD) || (s == ST_LANE_R);
  endfunction

  function automatic logic is_lane(input turn_state_e s);
    return (s == ST_LANE_L) || (s == ST_LANE_R);
  endfunction

endpackage

// File: rtl/turn_signal_ctrl_blink.sv
// Blink phase timer: ON and OFF phases of HALF_PERIOD cycles each.
// o_phase_on is the phase that will be in effect after the coming edge; o_off_edge is the raw wrap-from-ON.
module blink_timer #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_phase_on,
  output logic o_on_edge,
  output logic o_off_edge
);

  localparam int unsigned CNT_W = $clog2(HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  // Disabled means idle: counter and phase are held at zero so re-entry always starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (i_enable) begin
      if (w_wrap) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end
  end

  assign o_phase_on = i_restart | (i_enable & (r_phase ^ w_wrap));
  assign o_on_edge  = i_restart | (i_enable & w_wrap & ~r_phase);
  // Depends on registers only, so the FSM can use it to decide its next state without a loop.
  assign o_off_edge = w_wrap & r_phase;

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-indicator / hazard sequencer: arbitrates stalk, hazard and lane-change inputs and drives
// the lamp controller with blink-timed turn_left/turn_right plus a per-flash buzzer tick.
module turn_signal_ctrl
  import turn_signal_ctrl_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int unsigned LANE_BLINKS = DEF_LANE_BLINKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_turn_left,
  input  logic       sw_turn_right,
  input  logic       sw_hazard,
  input  logic       btn_lane_left,
  input  logic       btn_lane_right,
  output logic       turn_left,
  output logic       turn_right,
  output logic       blink_tick,
  output logic [2:0] turn_state
);

  localparam int unsigned LC_W = $clog2(LANE_BLINKS + 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LANE_BLINKS - 1);

  turn_state_e     r_state;
  turn_state_e     w_state_nxt;
  logic [LC_W-1:0] r_lane_cnt;
  logic [LC_W-1:0] w_lane_cnt_nxt;
  logic            r_btn_l_q;
  logic            r_btn_r_q;
  logic            r_turn_left;
  logic            r_turn_right;
  logic            r_blink_tick;

  logic w_rise_l;
  logic w_rise_r;
  logic w_lane_l_req;
  logic w_lane_r_req;
  logic w_restart;
  logic w_enable;
  logic w_phase_on;
  logic w_on_edge;
  logic w_off_edge;

  assign w_rise_l     = btn_lane_left & ~r_btn_l_q;
  assign w_rise_r     = btn_lane_right & ~r_btn_r_q;
  // Rising edges on both buttons in the same cycle are ambiguous and ignored.
  assign w_lane_l_req = w_rise_l & ~w_rise_r;
  assign w_lane_r_req = w_rise_r & ~w_rise_l;

  assign w_enable  = (w_state_nxt != ST_IDLE);
  assign w_restart = w_enable && (w_state_nxt != r_state);

  blink_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_blink_timer (
    .clk        (clk),
    .rst        (rst),
    .i_restart  (w_restart),
    .i_enable   (w_enable),
    .o_phase_on (w_phase_on),
    .o_on_edge  (w_on_edge),
    .o_off_edge (w_off_edge)
  );

  always_comb begin
    w_state_nxt    = ST_IDLE;
    w_lane_cnt_nxt = '0;
    if (sw_hazard) begin
      w_state_nxt = ST_HAZARD;
    end else if (sw_turn_left ^ sw_turn_right) begin
      w_state_nxt = sw_turn_left ? ST_LEFT : ST_RIGHT;
    end else if (sw_turn_left & sw_turn_right) begin
      w_state_nxt = ST_IDLE;
    end else if (w_lane_l_req) begin
      w_state_nxt = ST_LANE_L;
    end else if (w_lane_r_req) begin
      w_state_nxt = ST_LANE_R;
    end else if (is_lane(r_state)) begin
      // Count completed flashes at ON->OFF; the last one ends the lane change at that same edge.
      if (w_off_edge) begin
        if (r_lane_cnt >= LC_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt    = r_state;
          w_lane_cnt_nxt = r_lane_cnt + LC_W'(1);
        end
      end else begin
        w_state_nxt    = r_state;
        w_lane_cnt_nxt = r_lane_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lane_cnt   <= '0;
      r_btn_l_q    <= 1'b0;
      r_btn_r_q    <= 1'b0;
      r_turn_left  <= 1'b0;
      r_turn_right <= 1'b0;
      r_blink_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lane_cnt   <= w_lane_cnt_nxt;
      r_btn_l_q    <= btn_lane_left;
      r_btn_r_q    <= btn_lane_right;
      r_turn_left  <= w_phase_on & lights_left(w_state_nxt);
      r_turn_right <= w_phase_on & lights_right(w_state_nxt);
      r_blink_tick <= w_on_edge;
    end
  end

  assign turn_left  = r_turn_left;
  assign turn_right = r_turn_right;
  assign blink_tick = r_blink_tick;
  assign turn_state = r_state;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with HALF_PERIOD=4, LANE_BLINKS=3.
// Observed bundle is {turn_state[2:0], turn_left, turn_right, blink_tick}.
module tb_turn_signal_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_turn_left;
  logic       sw_turn_right;
  logic       sw_hazard;
  logic       btn_lane_left;
  logic       btn_lane_right;
  logic       turn_left;
  logic       turn_right;
  logic       blink_tick;
  logic [2:0] turn_state;
  logic [5:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  turn_signal_ctrl #(
    .HALF_PERIOD (4),
    .LANE_BLINKS (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_turn_left   (sw_turn_left),
    .sw_turn_right  (sw_turn_right),
    .sw_hazard      (sw_hazard),
    .btn_lane_left  (btn_lane_left),
    .btn_lane_right (btn_lane_right),
    .turn_left      (turn_left),
    .turn_right     (turn_right),
    .blink_tick     (blink_tick),
    .turn_state     (turn_state)
  );

  assign obs = {turn_state, turn_left, turn_right, blink_tick};

  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] exp;
    rst = 1'b1; sw_hazard = 1'b1;
    sw_turn_left = 1'b0; sw_turn_right = 1'b0;
    btn_lane_left = 1'b0; btn_lane_right = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      n_tests++;
      if (obs !== 6'b000_000) begin
        $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, 6'b000_000);
        n_fail++;
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick_clk();
      exp = {3'd3, 1'b1, 1'b1, (i == 0)};
      n_tests++;
      if (obs !== exp) begin
        $display("FAIL reset_release cyc %0d: got %b want %b", i, obs, exp);
        n_fail++;
      end
    end
    sw_hazard = 1'b0;
    tick_clk();
    n_tests++;
    if (obs !== 6'b000_000) begin
      $display("FAIL hazard_release: got %b want %b", obs, 6'b000_000);
      n_fail++;
    end
  endtask

  task automatic test_left_hold;
    logic [5:0] exp;
    sw_turn_left = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      exp = {3'd1, ((i % 8) < 4), 1'b0, ((i % 8) == 0)};
      n_tests++;
      if (obs !== exp) begin
        $display("FAIL left_hold cyc %0d: got %b want %b", i, obs, exp);
        n_fail++;
      end
    end
    sw_turn_left = 1'b0;
    tick_clk();
    n_tests++;
    if (obs !== 6'b000_000) begin
      $display("FAIL left_release: got %b want %b", obs, 6'b000_000);
      n_fail++;
    end
  endtask

  task automatic test_lane_right;
    logic [5:0] exp;
    int ticks = 0;
    btn_lane_right = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick_clk();
      btn_lane_right = 1'b0;
      if (i < 20) exp = {3'd5, 1'b0, ((i % 8) < 4), ((i % 8) == 0)};
      else        exp = 6'b000_000;
      if (blink_tick === 1'b1) ticks++;
      n_tests++;
      if (obs !== exp) begin
        $display("FAIL lane_right cyc %0d: got %b want %b", i, obs, exp);
        n_fail++;
      end
    end
    n_tests++;
    if (ticks != 3) begin
      $display("FAIL lane_right_ticks: got %0d want 3", ticks);
      n_fail++;
    end
  endtask

  task automatic test_lane_cancel;
    logic [5:0] exp;
    btn_lane_left = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      btn_lane_left = 1'b0;
      exp = {3'd4, ((i % 8) < 4), 1'b0, ((i % 8) == 0)};
      n_tests++;
      if (obs !== exp) begin
        $display("FAIL lane_left cyc %0d: got %b want %b", i, obs, exp);
        n_fail++;
      end
    end
    sw_hazard = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick_clk();
      exp = {3'd3, (j < 4), (j < 4), (j == 0)};
      n_tests++;
      if (obs !== exp) begin
        $display("FAIL lane_to_hazard cyc %0d: got %b want %b", j, obs, exp);
        n_fail++;
      end
    end
    sw_hazard = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick_clk();
      n_tests++;
      if (obs !== 6'b000_000) begin
        $display("FAIL lane_no_resume cyc %0d: got %b want %b", j, obs, 6'b000_000);
        n_fail++;
      end
    end
  endtask

  task automatic test_conflict;
    sw_turn_left = 1'b1; sw_turn_right = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      n_tests++;
      if (obs !== 6'b000_000) begin
        $display("FAIL conflict cyc %0d: got %b want %b", i, obs, 6'b000_000);
        n_fail++;
      end
    end
    sw_turn_right = 1'b0;
    tick_clk();
    n_tests++;
    if (obs !== {3'd1, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL conflict_to_left: got %b want %b", obs, {3'd1, 1'b1, 1'b0, 1'b1});
      n_fail++;
    end
    sw_turn_left = 1'b0;
    tick_clk();
    n_tests++;
    if (obs !== 6'b000_000) begin
      $display("FAIL conflict_release: got %b want %b", obs, 6'b000_000);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp;
    btn_lane_left = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_clk();
      btn_lane_left = 1'b0;
      exp = {3'd4, (i < 4), 1'b0, (i == 0)};
      n_tests++;
      if (obs !== exp) begin
        $display("FAIL b2b_left cyc %0d: got %b want %b", i, obs, exp);
        n_fail++;
      end
    end
    btn_lane_right = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick_clk();
      btn_lane_right = 1'b0;
      if (i < 20) exp = {3'd5, 1'b0, ((i % 8) < 4), ((i % 8) == 0)};
      else        exp = 6'b000_000;
      n_tests++;
      if (obs !== exp) begin
        $display("FAIL b2b_switch_right cyc %0d: got %b want %b", i, obs, exp);
        n_fail++;
      end
    end
    btn_lane_left = 1'b1; btn_lane_right = 1'b1;
    tick_clk();
    btn_lane_left = 1'b0; btn_lane_right = 1'b0;
    tick_clk();
    n_tests++;
    if (obs !== 6'b000_000) begin
      $display("FAIL both_buttons: got %b want %b", obs, 6'b000_000);
      n_fail++;
    end
  endtask

  task automatic test_lane_restart;
    logic [5:0] exp;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || i == 14) btn_lane_right = 1'b1;
      tick_clk();
      btn_lane_right = 1'b0;
      if (i < 36) exp = {3'd5, 1'b0, ((i % 8) < 4), ((i % 8) == 0)};
      else        exp = 6'b000_000;
      n_tests++;
      if (obs !== exp) begin
        $display("FAIL lane_restart cyc %0d: got %b want %b", i, obs, exp);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid;
    sw_turn_right = 1'b1;
    tick_clk();
    n_tests++;
    if (obs !== {3'd2, 1'b0, 1'b1, 1'b1}) begin
      $display("FAIL mid_entry: got %b want %b", obs, {3'd2, 1'b0, 1'b1, 1'b1});
      n_fail++;
    end
    tick_clk();
    n_tests++;
    if (obs !== {3'd2, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL mid_second: got %b want %b", obs, {3'd2, 1'b0, 1'b1, 1'b0});
      n_fail++;
    end
    rst = 1'b1;
    tick_clk();
    n_tests++;
    if (obs !== 6'b000_000) begin
      $display("FAIL mid_reset: got %b want %b", obs, 6'b000_000);
      n_fail++;
    end
    rst = 1'b0; sw_turn_right = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      n_tests++;
      if (obs !== 6'b000_000) begin
        $display("FAIL mid_release cyc %0d: got %b want %b", i, obs, 6'b000_000);
        n_fail++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_left_hold();
    test_lane_right();
    test_lane_cancel();
    test_conflict();
    test_back_to_back();
    test_lane_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
